// File: rtl/spice_node_integrator.sv
// spice_node_integrator
//   Sequential node model. A step snapshots N signed branch currents, sums
//   them over N cycles through a single adder, then integrates the sum into
//   the node voltage through a capacitance shift. The result is clamped to
//   the rails, and a hysteretic logic level is derived from it.
//
// Ports
//   clk      simulation clock
//   reset    synchronous, active-high reset
//   step     start one integration step (accepted only while idle)
//   i_bus    N signed currents, channel k at bits [k*W +: W]
//   v        node voltage, signed, registered
//   p        hysteretic logic level of v
//   busy     high while accumulating or applying
//   done     one-cycle pulse after v has been updated
//   overrun  sticky; set by a step that arrives while busy
//
// Handshake: step is a one-cycle request with no ready signal. It is taken
// at a clock edge only when busy is low. A step seen while busy is high is
// dropped and sets overrun. done pulses once for each accepted step, in the
// cycle right after v changes. Because the block is idle while done is high,
// a new step may be raised in that same cycle.
module spice_node_integrator #(
  parameter int W      = 16,
  parameter int N      = 4,
  parameter int CSHIFT = 2,
  parameter int V_HI   = 16384,
  parameter int V_LO   = -16384,
  parameter int V_INIT = 0,
  parameter int TH_HI  = 4096,
  parameter int TH_LO  = -4096
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           step,
  input  logic [N*W-1:0] i_bus,
  output logic [W-1:0]   v,
  output logic           p,
  output logic           busy,
  output logic           done,
  output logic           overrun
);

  // The accumulator is wide enough that N full-scale currents cannot overflow.
  // The voltage sum uses one more bit so that v + delta is always exact.
  localparam int AW = W + $clog2(N) + 1;
  localparam int SW = AW + 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic signed [SW-1:0] RAIL_HI = SW'(V_HI);
  localparam logic signed [SW-1:0] RAIL_LO = SW'(V_LO);
  localparam logic signed [W-1:0]  THR_HI  = W'(TH_HI);
  localparam logic signed [W-1:0]  THR_LO  = W'(TH_LO);
  localparam logic                 P_INIT  = (V_INIT > TH_HI) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    APPLY = 2'd2
  } state_t;

  state_t               state;
  logic signed [W-1:0]  snap [N];
  logic signed [AW-1:0] acc;
  logic [IW-1:0]        idx;

  logic signed [AW-1:0] delta;
  logic signed [SW-1:0] sum;
  logic signed [W-1:0]  v_next;
  logic                 p_next;

  assign busy = (state != IDLE);

  // Integration and clamping. Landing exactly on a rail is not a clamp, and
  // landing exactly on a threshold leaves p unchanged.
  always_comb begin
    delta = acc >>> CSHIFT;
    sum   = SW'($signed(v)) + SW'(delta);
    if (sum > RAIL_HI) begin
      v_next = W'(V_HI);
    end else if (sum < RAIL_LO) begin
      v_next = W'(V_LO);
    end else begin
      v_next = sum[W-1:0];
    end
    p_next = p;
    if (v_next > THR_HI) begin
      p_next = 1'b1;
    end else if (v_next < THR_LO) begin
      p_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      acc     <= '0;
      idx     <= '0;
      v       <= W'(V_INIT);
      p       <= P_INIT;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (step) begin
            // Snapshot all channels so that i_bus is free to move afterwards.
            for (int k = 0; k < N; k++) begin
              snap[k] <= $signed(i_bus[k*W +: W]);
            end
            acc   <= '0;
            idx   <= '0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc + AW'(snap[idx]);
          idx <= idx + IW'(1);
          if (idx == IW'(N - 1)) begin
            state <= APPLY;
          end
        end
        APPLY: begin
          v     <= v_next;
          p     <= p_next;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (step && (state != IDLE)) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spice_node_integrator.sv
module tb_spice_node_integrator;

  localparam int W = 16;
  localparam int N = 4;
  localparam int CSHIFT = 2;
  localparam int V_HI = 16384;
  localparam int V_LO = -16384;
  localparam int V_INIT = 0;
  localparam int TH_HI = 4096;
  localparam int TH_LO = -4096;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic           step;
  logic [N*W-1:0] i_bus;
  logic [W-1:0]   v;
  logic           p, busy, done, overrun;

  spice_node_integrator #(
    .W(W), .N(N), .CSHIFT(CSHIFT), .V_HI(V_HI), .V_LO(V_LO),
    .V_INIT(V_INIT), .TH_HI(TH_HI), .TH_LO(TH_LO)
  ) dut (
    .clk(clk), .reset(reset), .step(step), .i_bus(i_bus),
    .v(v), .p(p), .busy(busy), .done(done), .overrun(overrun)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: an accepted step fixes its result at once from the
  // currents present at that edge; the result appears N+1 edges later.
  int m_v, m_p, m_done, m_ovr, m_pend, m_nv, m_np;
  bit chk_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_v = V_INIT; m_p = (V_INIT > TH_HI); m_done = 0; m_ovr = 0; m_pend = 0;
      chk_en = 1'b1;
    end else begin
      m_done = 0;
      if (m_pend > 0) begin
        if (step) m_ovr = 1;
        m_pend--;
        if (m_pend == 0) begin
          m_v = m_nv; m_p = m_np; m_done = 1;
        end
      end else if (step) begin
        int total, s;
        total = 0;
        for (int k = 0; k < N; k++) begin
          int c;
          c = $signed(i_bus[k*W +: W]);
          total += c;
        end
        s = m_v + (total >>> CSHIFT);
        m_nv = (s > V_HI) ? V_HI : (s < V_LO) ? V_LO : s;
        m_np = (m_nv > TH_HI) ? 1 : (m_nv < TH_LO) ? 0 : m_p;
        m_pend = N + 1;
      end
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("v", $signed(v), m_v);
      check("p", {31'b0, p}, m_p);
      check("busy", {31'b0, busy}, (m_pend > 0) ? 1 : 0);
      check("done", {31'b0, done}, m_done);
      check("overrun", {31'b0, overrun}, m_ovr);
    end
  end

  // driver tasks
  function automatic logic [N*W-1:0] pack4(input int a, input int b, input int c, input int d);
    pack4 = {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    step = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run_step(input logic [N*W-1:0] bus, output int bcyc);
    bit got;
    step = 1'b1;
    i_bus = bus;
    @(negedge clk);
    step = 1'b0;
    i_bus = {$urandom, $urandom};
    bcyc = 0;
    got = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      if (busy) bcyc++;
      if (done) got = 1'b1;
      else @(negedge clk);
    end
    check("done_seen", {31'b0, got}, 1);
  endtask

  int bc;
  int done_cnt;

  initial begin
    reset = 1'b1;
    step = 1'b0;
    i_bus = '0;

    // reset and hold idle
    do_reset();
    idle(10);
    check("rst_v", $signed(v), 0);
    check("rst_p", {31'b0, p}, 0);

    // basic step: (400+400-200+200)>>>2 = 200
    run_step(pack4(400, 400, -200, 200), bc);
    check("busy_cycles", bc, 5);
    check("basic_v", $signed(v), 200);
    check("basic_p", {31'b0, p}, 0);
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("single_done", done_cnt, 0);

    // positive saturation: 131068>>>2 = 32767 clamps to 16384
    do_reset();
    run_step(pack4(32767, 32767, 32767, 32767), bc);
    check("sat_hi_v1", $signed(v), 16384);
    check("sat_hi_p1", {31'b0, p}, 1);
    run_step(pack4(32767, 32767, 32767, 32767), bc);  // back-to-back
    check("sat_hi_v2", $signed(v), 16384);

    // negative sweep from 5000
    do_reset();
    run_step(pack4(5000, 5000, 5000, 5000), bc);
    check("neg_v0", $signed(v), 5000);
    check("neg_p0", {31'b0, p}, 1);
    run_step(pack4(-8192, -8192, -8192, -8192), bc);
    check("neg_v1", $signed(v), -3192);
    check("neg_p1", {31'b0, p}, 1);
    run_step(pack4(-8192, -8192, -8192, -8192), bc);
    check("neg_v2", $signed(v), -11384);
    check("neg_p2", {31'b0, p}, 0);
    run_step(pack4(-8192, -8192, -8192, -8192), bc);
    check("neg_v3", $signed(v), -16384);

    // overrun: second step two edges after the first is dropped
    do_reset();
    step = 1'b1;
    i_bus = pack4(400, 400, -200, 200);
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    idle(10);
    check("ovr_v", $signed(v), 200);
    check("ovr_flag", {31'b0, overrun}, 1);
    idle(10);
    check("ovr_sticky", {31'b0, overrun}, 1);

    // reset during the second accumulate cycle aborts the step
    do_reset();
    run_step(pack4(400, 400, -200, 200), bc);
    check("pre_abort_v", $signed(v), 200);
    @(negedge clk);
    step = 1'b1;
    i_bus = pack4(8000, 8000, 8000, 8000);
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    check("abort_done", done_cnt, 0);
    check("abort_v", $signed(v), 0);
    run_step(pack4(400, 400, -200, 200), bc);
    check("post_abort_v", $signed(v), 200);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
